// File: rtl/pif_led_fader_pkg.sv
// pif_led_fader_pkg: LED mode codes, fade FSM states and mode width shared by the LED fader files.
package pif_led_fader_pkg;
  localparam int I2C_DATA_BITS = 8;
  localparam logic [I2C_DATA_BITS-1:0] LED_OFF = 8'h00, LED_ALTERNATING = 8'h01, LED_SYNC = 8'h02, LED_BREATHE = 8'h03;
  typedef enum logic [1:0] {FADE_IDLE, FADE_UP, FADE_DOWN} fade_state_t;
endpackage

// File: rtl/pif_led_fader_if.sv
// pif_led_fader_if: mode/flash inputs and LED drives between the register block and the fader.
interface pif_led_fader_if import pif_led_fader_pkg::*;;
  logic [I2C_DATA_BITS-1:0] mode;
  logic red_flash, green_flash, led_r, led_g;
  modport master (output mode, red_flash, green_flash, input led_r, led_g);
  modport slave (input mode, red_flash, green_flash, output led_r, led_g);
endinterface

// File: rtl/pif_fade_ramp.sv
// pif_fade_ramp: triangular fade level, one step every STEP_PERIODS PWM periods while breathing.
module pif_fade_ramp import pif_led_fader_pkg::*; #(
  parameter int PWM_BITS = 8,
  parameter int STEP_PERIODS = 4
) (
  input logic xclk,
  input logic sys_rst,
  input logic pe,
  input logic en,
  output logic [PWM_BITS-1:0] level,
  output fade_state_t dir
);
  localparam int SW = STEP_PERIODS > 1 ? $clog2(STEP_PERIODS) : 1;
  logic [SW-1:0] step_cnt;
  logic step, go_up;
  assign step = step_cnt == SW'(STEP_PERIODS - 1);
  // at a bound the direction flips and the same step already moves away from it
  assign go_up = dir == FADE_UP ? !(&level) : level == '0;
  always_ff @(posedge xclk) begin
    if (sys_rst || (pe && !en)) begin
      dir <= FADE_IDLE;
      level <= '0;
      step_cnt <= '0;
    end else if (pe) begin
      if (dir == FADE_IDLE) begin
        dir <= FADE_UP;
      end else begin
        step_cnt <= step ? '0 : step_cnt + 1'b1;
        if (step) begin
          dir <= go_up ? FADE_UP : FADE_DOWN;
          level <= go_up ? level + 1'b1 : level - 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/pif_led_fader.sv
// pif_led_fader: PWM dimming and breathe fade for LEDR/LEDG; mode changes land on PWM period ends.
// Define LED_GAMMA_EN to square the duty for a perceptual brightness curve.
module pif_led_fader import pif_led_fader_pkg::*; #(
  parameter int PWM_BITS = 8,
  parameter int PRESCALE_DIV = 16,
  parameter int STEP_PERIODS = 4,
  parameter logic [PWM_BITS-1:0] FULL_DUTY = '1
) (
  input logic xclk,
  input logic sys_rst,
  pif_led_fader_if.slave bus
);
  localparam int PW = PRESCALE_DIV > 1 ? $clog2(PRESCALE_DIV) : 1;
  logic [PW-1:0] presc;
  logic [PWM_BITS-1:0] pwm_cnt, level, duty, duty_eff;
  logic [I2C_DATA_BITS-1:0] mode_q;
  fade_state_t dir;
  logic tick, pe, on, r_nxt, g_nxt;
  assign tick = presc == PW'(PRESCALE_DIV - 1);
  assign pe = tick && &pwm_cnt;
  assign duty = mode_q == LED_BREATHE ? level : FULL_DUTY;
`ifdef LED_GAMMA_EN
  logic [2*PWM_BITS-1:0] sq;
  assign sq = (2*PWM_BITS)'(duty) * (2*PWM_BITS)'(duty);
  assign duty_eff = sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign duty_eff = duty;
`endif
  assign on = pwm_cnt < duty_eff;
  assign r_nxt = (mode_q == LED_ALTERNATING || mode_q == LED_SYNC) ? bus.red_flash & on
               : mode_q == LED_BREATHE && dir == FADE_UP && on;
  assign g_nxt = mode_q == LED_ALTERNATING ? bus.green_flash & on
               : mode_q == LED_SYNC ? bus.red_flash & on
               : mode_q == LED_BREATHE && dir == FADE_DOWN && on;
  // the ramp sees the mode that mode_q is about to take, so entry and exit share the pe
  pif_fade_ramp #(.PWM_BITS(PWM_BITS), .STEP_PERIODS(STEP_PERIODS)) u_ramp (
    .xclk(xclk),
    .sys_rst(sys_rst),
    .pe(pe),
    .en((pe ? bus.mode : mode_q) == LED_BREATHE),
    .level(level),
    .dir(dir)
  );
  always_ff @(posedge xclk) begin
    if (sys_rst) begin
      presc <= '0;
      pwm_cnt <= '0;
      mode_q <= LED_OFF;
      bus.led_r <= 1'b0;
      bus.led_g <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
      if (pe) mode_q <= bus.mode;
      bus.led_r <= r_nxt;
      bus.led_g <= g_nxt;
    end
  end
endmodule

// File: tb/tb_pif_led_fader.sv
// tb_pif_led_fader: directed and random stimulus against a period-level model of the LED fader.
module tb_pif_led_fader;
  import pif_led_fader_pkg::*;
  localparam int PB = 4;
  localparam int N = 1 << PB;
  logic xclk = 1'b0;
  logic sys_rst = 1'b1;
  int errors = 0, checks = 0;
  int c = 0, bstart = -1, hr = 0, hg = 0;
  logic [I2C_DATA_BITS-1:0] mode_cur = LED_OFF;
  pif_led_fader_if bus();
  pif_led_fader #(.PWM_BITS(PB), .PRESCALE_DIV(1), .STEP_PERIODS(1)) dut (.xclk(xclk), .sys_rst(sys_rst), .bus(bus));
  always #5 xclk = ~xclk;

  function automatic int eff(int d);
`ifdef LED_GAMMA_EN
    return (d * d) >> PB;
`else
    return d;
`endif
  endfunction

  task automatic edge_check(string tag);
    int p, k, j, u, lvl, duty;
    logic er, eg, on, up;
    er = 1'b0;
    eg = 1'b0;
    @(posedge xclk);
    if (sys_rst) begin
      c = 0;
      mode_cur = LED_OFF;
      bstart = -1;
    end else begin
      p = c % N;
      k = c / N;
      up = 1'b1;
      lvl = 0;
      if (mode_cur == LED_BREATHE) begin
        j = k - bstart;
        if (j > 0) begin
          u = (j - 1) % (2 * (N - 1));
          up = u < N - 1;
          lvl = up ? u + 1 : 2 * (N - 1) - 1 - u;
        end
      end
      duty = eff(mode_cur == LED_BREATHE ? lvl : N - 1);
      on = p < duty;
      if (mode_cur == LED_ALTERNATING) begin
        er = bus.red_flash & on;
        eg = bus.green_flash & on;
      end else if (mode_cur == LED_SYNC) begin
        er = bus.red_flash & on;
        eg = bus.red_flash & on;
      end else if (mode_cur == LED_BREATHE) begin
        er = up & on;
        eg = !up & on;
      end
      if (p == N - 1) begin
        if (bus.mode == LED_BREATHE && mode_cur != LED_BREATHE) bstart = k + 1;
        mode_cur = bus.mode;
      end
      c++;
    end
    #1;
    checks += 2;
    assert (bus.led_r === er) else begin
      errors++;
      $error("FAIL %s led_r cycle %0d: got %b expected %b", tag, c, bus.led_r, er);
    end
    assert (bus.led_g === eg) else begin
      errors++;
      $error("FAIL %s led_g cycle %0d: got %b expected %b", tag, c, bus.led_g, eg);
    end
    hr += int'(bus.led_r === 1'b1);
    hg += int'(bus.led_g === 1'b1);
  endtask

  task automatic run(string tag, int n, bit rnd);
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        bus.red_flash = 1'($urandom);
        bus.green_flash = 1'($urandom);
      end
      edge_check(tag);
    end
  endtask

  task automatic run_until(string tag, logic [I2C_DATA_BITS-1:0] want_mode, int want_p, int want_j, bit rnd);
    int n;
    n = 0;
    while (n < 400 && !(c % N == want_p && mode_cur == want_mode && (want_j < 0 || c / N - bstart == want_j))) begin
      run(tag, 1, rnd);
      n++;
    end
    checks++;
    assert (n < 400) else begin
      errors++;
      $error("FAIL %s wait: got %0d cycles expected under 400", tag, n);
    end
  endtask

  task automatic count_period(string tag, int want_r, int want_g);
    hr = 0;
    hg = 0;
    run(tag, N, 1'b0);
    checks += 2;
    assert (hr == want_r) else begin
      errors++;
      $error("FAIL %s led_r highs: got %0d expected %0d", tag, hr, want_r);
    end
    assert (hg == want_g) else begin
      errors++;
      $error("FAIL %s led_g highs: got %0d expected %0d", tag, hg, want_g);
    end
  endtask

  initial begin
    bus.mode = LED_SYNC;
    bus.red_flash = 1'b1;
    bus.green_flash = 1'b0;
    sys_rst = 1'b1;
    run("reset", 3, 1'b0);
    sys_rst = 1'b0;
    run("sync_wait", N, 1'b0);
    count_period("sync_duty", eff(N - 1), eff(N - 1));
    run("sync_rand", 2 * N, 1'b1);
    bus.mode = LED_ALTERNATING;
    bus.red_flash = 1'b1;
    bus.green_flash = 1'b0;
    run_until("alt_align", LED_ALTERNATING, 0, -1, 1'b0);
    count_period("alt_duty", eff(N - 1), 0);
    run("alt_rand", 3 * N, 1'b1);
    bus.mode = LED_OFF;
    run_until("off_align", LED_OFF, 3, -1, 1'b1);
    bus.mode = LED_ALTERNATING;
    bus.red_flash = 1'b1;
    bus.green_flash = 1'b1;
    run("off_to_alt", 2 * N, 1'b0);
    bus.mode = 8'hA5;
    run("undef_code", 3 * N, 1'b1);
    bus.mode = LED_BREATHE;
    run_until("breathe_l8", LED_BREATHE, 0, 8, 1'b1);
    count_period("breathe_l8", eff(8), 0);
    run("breathe", 600, 1'b1);
    bus.mode = LED_OFF;
    run_until("rearm_off", LED_OFF, 0, -1, 1'b1);
    bus.mode = LED_BREATHE;
    run_until("ramp_l7", LED_BREATHE, 0, 7, 1'b1);
    bus.mode = LED_OFF;
    run("ramp_stop", N, 1'b1);
    count_period("ramp_off", 0, 0);
    bus.mode = LED_BREATHE;
    run("ramp_restart", 8 * N, 1'b1);
    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(0, 4))
        0: bus.mode = LED_OFF;
        1: bus.mode = LED_ALTERNATING;
        2: bus.mode = LED_SYNC;
        3: bus.mode = LED_BREATHE;
        default: bus.mode = 8'($urandom);
      endcase
      run("rand_mode", $urandom_range(1, 3 * N), 1'b1);
    end
    bus.mode = LED_BREATHE;
    run("pre_reset", 10 * N, 1'b1);
    sys_rst = 1'b1;
    run("mid_reset", 2, 1'b1);
    sys_rst = 1'b0;
    run("post_reset", 4 * N, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
